pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 4-stage IF/ID/EXE/WB core. Tracks the destination register of the

---
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 4-stage IF/ID/EXE/WB pipe: RAW detection against a
// two-entry shadow scoreboard (EXE, WB) and a hold FSM for the multi-cycle multiply.
module pipe_hazard_ctrl #(
    parameter int         ASIZE   = 5,
    parameter int         MUL_LAT = 4,
    parameter logic [2:0] MUL_OP  = 3'd7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [ASIZE-1:0] id_raddr1,
    input  logic [ASIZE-1:0] id_raddr2,
    input  logic             id_uses_r2,
    input  logic [ASIZE-1:0] id_waddr,
    input  logic [2:0]       id_aluop,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idexe_bubble,
    output logic             idexe_hold,
    output logic             exewb_bubble,
    output logic             exe_busy,
    output logic [15:0]      stall_cycles
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic {RUN, BUSY} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ex_v_q, ex_v_d, wb_v_q, wb_v_d;
    logic [ASIZE-1:0] ex_waddr_q, ex_waddr_d, wb_waddr_q, wb_waddr_d;
    logic [15:0]      stall_q, stall_d;
    logic             m1, m2, raw;

    // No write-to-read bypass in the register file, so a match in WB still blocks.
    assign m1  = (id_raddr1 != '0) && ((ex_v_q && id_raddr1 == ex_waddr_q) ||
                                        (wb_v_q && id_raddr1 == wb_waddr_q));
    assign m2  = (id_raddr2 != '0) && ((ex_v_q && id_raddr2 == ex_waddr_q) ||
                                        (wb_v_q && id_raddr2 == wb_waddr_q));
    assign raw = id_valid && (m1 || (id_uses_r2 && m2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            ex_v_q     <= 1'b0;
            ex_waddr_q <= '0;
            wb_v_q     <= 1'b0;
            wb_waddr_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_v_q     <= ex_v_d;
            ex_waddr_q <= ex_waddr_d;
            wb_v_q     <= wb_v_d;
            wb_waddr_q <= wb_waddr_d;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_v_d     = ex_v_q;
        ex_waddr_d = ex_waddr_q;
        wb_v_d     = wb_v_q;
        wb_waddr_d = wb_waddr_q;
        case (state_q)
            RUN: begin
                wb_v_d     = ex_v_q;
                wb_waddr_d = ex_waddr_q;
                if (raw) begin
                    ex_v_d = 1'b0;
                end else begin
                    ex_v_d     = id_valid && (id_waddr != '0);
                    ex_waddr_d = id_waddr;
                    if (id_valid && id_aluop == MUL_OP && MUL_LAT > 1) begin
                        state_d = BUSY;
                        cnt_d   = CW'(MUL_LAT - 1);
                    end
                end
            end
            BUSY: begin
                // Multiply stays parked in EXE; WB drains to a bubble.
                wb_v_d = 1'b0;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idexe_bubble = 1'b0;
        idexe_hold   = 1'b0;
        exewb_bubble = 1'b0;
        exe_busy     = 1'b0;
        if (state_q == BUSY) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idexe_hold   = 1'b1;
            exewb_bubble = 1'b1;
            exe_busy     = 1'b1;
        end else if (raw) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idexe_bubble = 1'b1;
        end
    end

    assign stall_d      = (pc_stall && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic checked against
// a model that tracks pending destination registers per stage and remaining multiply cycles.
module tb_pipe_hazard_ctrl;

    localparam int AW  = 5;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_r2;
    logic [AW-1:0] id_raddr1, id_raddr2, id_waddr;
    logic [2:0]    id_aluop;
    logic          pc_stall, ifid_stall, idexe_bubble, idexe_hold, exewb_bubble, exe_busy;
    logic [15:0]   stall_cycles;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.ASIZE(AW), .MUL_LAT(LAT), .MUL_OP(3'd7)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_raddr1(id_raddr1),
        .id_raddr2(id_raddr2), .id_uses_r2(id_uses_r2), .id_waddr(id_waddr),
        .id_aluop(id_aluop), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idexe_bubble(idexe_bubble), .idexe_hold(idexe_hold), .exewb_bubble(exewb_bubble),
        .exe_busy(exe_busy), .stall_cycles(stall_cycles)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending destination in EXE (dst[0]) and WB (dst[1]); 0 = nothing pending.
    int   dst [2];
    int   busy_left;
    int   stalls;
    logic e_pc, e_ifid, e_bub, e_hold, e_exewb, e_busy;

    function automatic bit pending(int a);
        return a != 0 && (a == dst[0] || a == dst[1]);
    endfunction

    task automatic predict();
        {e_pc, e_ifid, e_bub, e_hold, e_exewb, e_busy} = '0;
        if (busy_left > 0) begin
            {e_pc, e_ifid, e_hold, e_exewb, e_busy} = '1;
        end else if (id_valid && (pending(int'(id_raddr1)) ||
                                  (id_uses_r2 && pending(int'(id_raddr2))))) begin
            {e_pc, e_ifid, e_bub} = '1;
        end
    endtask

    task automatic advance();
        if (rst) begin
            dst[0] = 0; dst[1] = 0; busy_left = 0; stalls = 0;
        end else begin
            if (e_pc && stalls < 65535) stalls++;
            if (busy_left > 0) begin
                busy_left--;
                dst[1] = 0;
            end else if (e_bub) begin
                dst[1] = dst[0];
                dst[0] = 0;
            end else begin
                dst[1] = dst[0];
                dst[0] = id_valid ? int'(id_waddr) : 0;
                if (id_valid && id_aluop == 3'd7 && LAT > 1) busy_left = LAT - 1;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic u, input logic [AW-1:0] wa, input logic [2:0] op);
        id_valid = v; id_raddr1 = r1; id_raddr2 = r2; id_uses_r2 = u; id_waddr = wa; id_aluop = op;
        #1;
        predict();
    endtask

    task automatic tick();
        advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, 3'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 3'd0);
        total++; if (pc_stall !== 1'b0) begin bad++; $display("FAIL reset_pc got=%b exp=0", pc_stall); end
        total++; if (ifid_stall !== 1'b0) begin bad++; $display("FAIL reset_ifid got=%b exp=0", ifid_stall); end
        total++; if (idexe_bubble !== 1'b0) begin bad++; $display("FAIL reset_bubble got=%b exp=0", idexe_bubble); end
        total++; if (idexe_hold !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b exp=0", idexe_hold); end
        total++; if (exewb_bubble !== 1'b0) begin bad++; $display("FAIL reset_exewb got=%b exp=0", exewb_bubble); end
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", exe_busy); end
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
        tick();
    endtask

    task automatic test_independent();
        do_reset();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 5'd1, 3'd0);
        total++; if (pc_stall !== 1'b0) begin bad++; $display("FAIL indep_pc0 got=%b exp=0", pc_stall); end
        tick();
        drive(1'b1, 5'd5, 5'd6, 1'b1, 5'd4, 3'd0);
        total++; if (pc_stall !== 1'b0) begin bad++; $display("FAIL indep_pc1 got=%b exp=0", pc_stall); end
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, 3'd0);
        total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL indep_cnt got=%0d exp=0", stall_cycles); end
        tick();
    endtask

    task automatic test_raw();
        do_reset();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 5'd1, 3'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 3'd1);
            total++; if (pc_stall !== (c < 2)) begin bad++; $display("FAIL raw_pc c%0d got=%b exp=%b", c, pc_stall, c < 2); end
            total++; if (idexe_bubble !== (c < 2)) begin bad++; $display("FAIL raw_bub c%0d got=%b exp=%b", c, idexe_bubble, c < 2); end
            tick();
        end
        // SUB now sits in EXE, so a reader of r7 must stall immediately.
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd8, 3'd0);
        total++; if (pc_stall !== 1'b1) begin bad++; $display("FAIL raw_sub_in_exe got=%b exp=1", pc_stall); end
        total++; if (stall_cycles !== 16'd2) begin bad++; $display("FAIL raw_cnt got=%0d exp=2", stall_cycles); end
        tick();
    endtask

    task automatic test_no_r2();
        do_reset();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 5'd1, 3'd0);
        tick();
        drive(1'b1, 5'd2, 5'd1, 1'b0, 5'd4, 3'd2);
        total++; if (pc_stall !== 1'b0) begin bad++; $display("FAIL itype_pc got=%b exp=0", pc_stall); end
        tick();
        drive(1'b1, 5'd2, 5'd3, 1'b1, 5'd0, 3'd0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 3'd0);
        total++; if (pc_stall !== 1'b0) begin bad++; $display("FAIL r0_pc got=%b exp=0", pc_stall); end
        tick();
    endtask

    task automatic test_mul();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 3'd7);
        total++; if (exe_busy !== 1'b0) begin bad++; $display("FAIL mul_issue_busy got=%b exp=0", exe_busy); end
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 5'd5, 5'd6, 1'b1, 5'd4, 3'd0);
            total++; if (exe_busy !== (c < 3)) begin bad++; $display("FAIL mul_busy c%0d got=%b exp=%b", c, exe_busy, c < 3); end
            total++; if (idexe_hold !== (c < 3)) begin bad++; $display("FAIL mul_hold c%0d got=%b exp=%b", c, idexe_hold, c < 3); end
            total++; if (exewb_bubble !== (c < 3)) begin bad++; $display("FAIL mul_exewb c%0d got=%b exp=%b", c, exewb_bubble, c < 3); end
            total++; if (idexe_bubble !== 1'b0) begin bad++; $display("FAIL mul_bub c%0d got=%b exp=0", c, idexe_bubble); end
            total++; if (pc_stall !== (c < 3)) begin bad++; $display("FAIL mul_pc c%0d got=%b exp=%b", c, pc_stall, c < 3); end
            tick();
        end
    endtask

    task automatic test_mul_raw();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 3'd7);
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 5'd3, 5'd0, 1'b1, 5'd4, 3'd0);
            total++; if (exe_busy !== (c < 3)) begin bad++; $display("FAIL mraw_busy c%0d got=%b exp=%b", c, exe_busy, c < 3); end
            total++; if (idexe_bubble !== (c == 3 || c == 4)) begin bad++; $display("FAIL mraw_bub c%0d got=%b exp=%b", c, idexe_bubble, c == 3 || c == 4); end
            total++; if (pc_stall !== (c < 5)) begin bad++; $display("FAIL mraw_pc c%0d got=%b exp=%b", c, pc_stall, c < 5); end
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, '0, 3'd0);
        total++; if (stall_cycles !== 16'd5) begin bad++; $display("FAIL mraw_cnt got=%0d exp=5", stall_cycles); end
        tick();
    endtask

    task automatic test_reset_busy();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 3'd7);
        tick();
        drive(1'b1, 5'd5, 5'd6, 1'b1, 5'd4, 3'd0);
        tick();
        rst = 1'b1;
        drive(1'b1, 5'd5, 5'd6, 1'b1, 5'd4, 3'd0);
        total++; if (exe_busy !== 1'b1) begin bad++; $display("FAIL rbusy_pre got=%b exp=1", exe_busy); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 5'd5, 5'd6, 1'b1, 5'd4, 3'd0);
            total++; if ({pc_stall, ifid_stall, idexe_bubble, idexe_hold, exewb_bubble, exe_busy} !== 6'b0)
                begin bad++; $display("FAIL rbusy_outs c%0d got=%b exp=000000", c,
                    {pc_stall, ifid_stall, idexe_bubble, idexe_hold, exewb_bubble, exe_busy}); end
            total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL rbusy_cnt c%0d got=%0d exp=0", c, stall_cycles); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            total++; if (pc_stall !== e_pc) begin bad++; $display("FAIL rnd_pc i%0d got=%b exp=%b", i, pc_stall, e_pc); end
            total++; if (ifid_stall !== e_ifid) begin bad++; $display("FAIL rnd_ifid i%0d got=%b exp=%b", i, ifid_stall, e_ifid); end
            total++; if (idexe_bubble !== e_bub) begin bad++; $display("FAIL rnd_bub i%0d got=%b exp=%b", i, idexe_bubble, e_bub); end
            total++; if (idexe_hold !== e_hold) begin bad++; $display("FAIL rnd_hold i%0d got=%b exp=%b", i, idexe_hold, e_hold); end
            total++; if (exewb_bubble !== e_exewb) begin bad++; $display("FAIL rnd_exewb i%0d got=%b exp=%b", i, exewb_bubble, e_exewb); end
            total++; if (exe_busy !== e_busy) begin bad++; $display("FAIL rnd_busy i%0d got=%b exp=%b", i, exe_busy, e_busy); end
            total++; if (int'(stall_cycles) != stalls) begin bad++; $display("FAIL rnd_cnt i%0d got=%0d exp=%0d", i, stall_cycles, stalls); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_raddr1 = '0; id_raddr2 = '0; id_uses_r2 = 1'b0; id_waddr = '0; id_aluop = '0;
        dst[0] = 0; dst[1] = 0; busy_left = 0; stalls = 0;
        @(negedge clk);
        test_reset();
        test_independent();
        test_raw();
        test_no_r2();
        test_mul();
        test_mul_raw();
        test_reset_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
